// File: rtl/prepro_frame_buffer.sv
// -----------------------------------------------------------------------------
// prepro_frame_buffer
//
// Circular speech buffer that sits behind the pre-processor high-pass filter.
// Each filtered sample is captured on the pre-processor done strobe and stored
// in a WIN_LEN-deep ring (120 past + 80 current + 40 look-ahead samples).
// Every FRAME_LEN samples a new analysis window is announced on frame_ready_o,
// and the LPC/windowing stage reads it by logical index (0 = oldest sample).
// After reset the whole ring is zeroed, one word per cycle, before samples
// are accepted.
//
// Optional build macro: PREPRO_FRAME_CNT_EN adds frame_count_o, a 16-bit
// wrapping count of completed frames (overrun frames included).
//
// Ports:
//   mclk            clock
//   reset           synchronous, active-high reset
//   sample_in_i     rounded filter output y[n]
//   sample_valid_i  one-cycle strobe, pre-processor done
//   busy_o          high while the ring is being cleared
//   frame_ready_o   level, a new window is available
//   frame_ack_i     one-cycle strobe from the consumer, clears frame_ready_o
//   rd_en_i         read request
//   rd_addr_i       logical window index, 0..WIN_LEN-1
//   rd_data_o       registered read data (one-cycle latency)
//   rd_valid_o      qualifies rd_data_o
//   overrun_o       sticky error flag, cleared only by reset
//   frame_count_o   completed-frame counter (PREPRO_FRAME_CNT_EN only)
// -----------------------------------------------------------------------------
module prepro_frame_buffer #(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 80,
   parameter int WIN_LEN   = 240,
   parameter int ADDR_W    = 8
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in_i,
   input  logic              sample_valid_i,
   output logic              busy_o,
   output logic              frame_ready_o,
   input  logic              frame_ack_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              overrun_o
`ifdef PREPRO_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_count_o
`endif
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN_LEN - 1);
   localparam logic [ADDR_W-1:0] WIN_SIZE = ADDR_W'(WIN_LEN);
   localparam logic [ADDR_W:0]   WIN_EXT  = (ADDR_W + 1)'(WIN_LEN);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  samp_cnt_q, samp_cnt_d;
   logic              frame_ready_q, frame_ready_d;
   logic              overrun_q, overrun_d;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              frame_done;

   logic [DATA_W-1:0] mem_q [WIN_LEN];

   // Logical-to-physical mapping: the sum is one bit wider than the pointers
   // so base + index never overflows before the modulo fold.
   logic [ADDR_W:0]   rd_sum;
   logic [ADDR_W:0]   rd_fold;
   logic [ADDR_W-1:0] rd_phys;
   logic              rd_oob;

   always_comb begin
      rd_sum  = {1'b0, base_q} + {1'b0, rd_addr_i};
      rd_fold = rd_sum - WIN_EXT;
      rd_phys = (rd_sum >= WIN_EXT) ? rd_fold[ADDR_W-1:0] : rd_sum[ADDR_W-1:0];
      rd_oob  = (rd_addr_i >= WIN_SIZE);
   end

   // Next-state logic: clearing sweep, sample capture and frame bookkeeping.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case/if tree can leave it unassigned and infer a latch.
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      clr_ptr_d     = clr_ptr_q;
      base_d        = base_q;
      samp_cnt_d    = samp_cnt_q;
      frame_ready_d = frame_ready_q;
      overrun_d     = overrun_q;
      mem_we        = 1'b0;
      mem_waddr     = wr_ptr_q;
      mem_wdata     = sample_in_i;
      frame_done    = 1'b0;

      unique case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == WIN_LAST) begin
               clr_ptr_d = '0;
               state_d   = S_RUN;
            end
            // A sample arriving before the ring is ready is dropped.
            if (sample_valid_i) overrun_d = 1'b1;
         end
         S_RUN: begin
            if (sample_valid_i) begin
               mem_we     = 1'b1;
               wr_ptr_d   = (wr_ptr_q == WIN_LAST) ? '0 : wr_ptr_q + ADDR_W'(1);
               samp_cnt_d = (samp_cnt_q == CNT_LAST) ? '0 : samp_cnt_q + CNT_W'(1);
               if (samp_cnt_q == CNT_LAST) begin
                  frame_done = 1'b1;
                  // The slot after the newest sample holds the oldest one.
                  base_d     = wr_ptr_d;
               end
            end
         end
         default: state_d = S_CLEAR;
      endcase

      // A completion wins over a coincident ack; an unacknowledged previous
      // frame being replaced is the overrun condition.
      if (frame_done) begin
         frame_ready_d = 1'b1;
         if (frame_ready_q && !frame_ack_i) overrun_d = 1'b1;
      end else if (frame_ack_i) begin
         frame_ready_d = 1'b0;
      end
   end

   always_ff @(posedge mclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q       <= S_CLEAR;
         wr_ptr_q      <= '0;
         clr_ptr_q     <= '0;
         base_q        <= '0;
         samp_cnt_q    <= '0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         clr_ptr_q     <= clr_ptr_d;
         base_q        <= base_d;
         samp_cnt_q    <= samp_cnt_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
         rd_valid_q    <= rd_en_i;
         // Reading the array here sees the pre-edge contents, giving
         // read-before-write when a sample lands on the same slot.
         if (rd_en_i) rd_data_q <= rd_oob ? '0 : mem_q[rd_phys];
      end
   end

   // NOTE: the array has no reset term so it can map onto block RAM; the
   // CLEAR sweep zeroes it instead after every reset.
   always_ff @(posedge mclk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

`ifdef PREPRO_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge mclk) begin
      if (reset)           frame_cnt_q <= '0;
      else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_count_o = frame_cnt_q;
`endif

   assign busy_o        = (state_q == S_CLEAR);
   assign frame_ready_o = frame_ready_q;
   assign overrun_o     = overrun_q;
   assign rd_valid_o    = rd_valid_q;
   assign rd_data_o     = rd_data_q;

endmodule
